// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// registered operands, one-cycle execute, held response with per-owner handshake.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [2:0]       req0_op_i,
  input  logic [2:0]       req1_op_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  input  logic             rsp0_ready_i,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             grant0_c, grant1_c;

  // Next-state, grant and datapath-load logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    grant0_c     = 1'b0;
    grant1_c     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not served last wins
        if (req0_valid_i && (!req1_valid_i || last_q)) begin
          grant0_c = 1'b1;
        end else if (req1_valid_i) begin
          grant1_c = 1'b1;
        end
        if (grant0_c) begin
          alu_a_d    = req0_a_i;
          alu_b_d    = req0_b_i;
          alu_ctrl_d = req0_op_i;
          owner_d    = 1'b0;
          state_d    = EXEC;
        end else if (grant1_c) begin
          alu_a_d    = req1_a_i;
          alu_b_d    = req1_b_i;
          alu_ctrl_d = req1_op_i;
          owner_d    = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result_i;
        rsp_zero_d   = alu_zero_i;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_d       = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 3'b000;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // Readies are same-cycle handshakes; forced low while reset is held
  assign req0_ready_o  = grant0_c & rst_ni;
  assign req1_ready_o  = grant1_c & rst_ni;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_control_o = alu_ctrl_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp0_valid_o  = rsp0_valid_q;
  assign rsp1_valid_o  = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small local ALU (000 SLT, 001 ADD, else SUB).
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_control;
  logic             alu_zero;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .req0_op_i(req0_op), .req1_op_i(req1_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_control_o(alu_control),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid),
    .rsp0_ready_i(rsp0_ready), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero)
  );

  always_comb begin
    case (alu_control)
      3'b000:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b001:  alu_result = alu_a + alu_b;
      default: alu_result = alu_a - alu_b;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    #3;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b%b exp 00", rsp0_valid, rsp1_valid); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_ab got %0d/%0d exp 0/0", alu_a, alu_b); end
    checks++; if (alu_control !== 3'b000) begin errors++; $display("FAIL reset_alu_control got %b exp 000", alu_control); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_data got %0d/%b exp 0/0", rsp_result, rsp_zero); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    step();
    req0_valid = 1; req0_a = 32'd7; req0_b = 32'd8; req0_op = 3'b000;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready); end
    step(); req0_valid = 0;
    @(negedge clk);
    checks++; if (alu_a !== 32'd7 || alu_b !== 32'd8) begin errors++; $display("FAIL single_alu_ab got %0d/%0d exp 7/8", alu_a, alu_b); end
    checks++; if (rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL single_exec got v%b r%b exp v0 r0", rsp0_valid, req0_ready); end
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid got %b%b exp 10", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin errors++; $display("FAIL single_rsp_data got %0d/%b exp 1/0", rsp_result, rsp_zero); end
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b exp 0", rsp0_valid); end
  endtask

  task automatic test_tie();
    do_reset();
    step();
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd2; req0_op = 3'b000;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd8; req1_op = 3'b000;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_first_grant got %b%b exp 10", req0_ready, req1_ready); end
    step(); req0_valid = 0;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie_wait_exec got %b exp 0", req1_ready); end
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_rsp0 got v%b%b r%b exp v10 r0", rsp0_valid, rsp1_valid, req1_ready); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL tie_rsp0_data got %0d/%b exp 0/1", rsp_result, rsp_zero); end
    step();
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL tie_second_grant got %b exp 1", req1_ready); end
    step(); req1_valid = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL tie_rsp1 got %b%b exp 01", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin errors++; $display("FAIL tie_rsp1_data got %0d/%b exp 1/0", rsp_result, rsp_zero); end
    step();
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    int grants = 0;
    step();
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'b001;
    req1_valid = 1; req1_a = 32'd20; req1_b = 32'd4; req1_op = 3'b010;
    for (int cyc = 0; cyc < 20 && grants < 4; cyc++) begin
      @(negedge clk);
      checks++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin errors++; $display("FAIL rr_both_ready cycle %0d got 11 exp at most one", cyc); end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        checks++; if ((req1_ready ? 1 : 0) !== exp_g[grants]) begin errors++; $display("FAIL rr_order grant %0d got %0d exp %0d", grants, req1_ready ? 1 : 0, exp_g[grants]); end
        grants++;
      end
      step();
      if (grants == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (grants !== 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", grants); end
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    step();
    req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b001;
    rsp1_ready = 0; rsp0_ready = 1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req1_ready); end
    step(); req1_valid = 0;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b001;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_wait_exec got %b exp 0", req0_ready); end
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'd7 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got v%b%b res %0d exp v01 res 7", i, rsp0_valid, rsp1_valid, rsp_result); end
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_wait cycle %0d got %b exp 0", i, req0_ready); end
      step();
    end
    rsp1_ready = 1;
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_release got v%b r%b exp v1 r0", rsp1_valid, req0_ready); end
    step();
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_accept got v%b r%b exp v0 r1", rsp1_valid, req0_ready); end
    step(); req0_valid = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd3) begin errors++; $display("FAIL bp_held_req_rsp got v%b res %0d exp v1 res 3", rsp0_valid, rsp_result); end
    step();
  endtask

  task automatic test_operand_change();
    step();
    req0_valid = 1; req0_a = 32'd25; req0_b = 32'd25; req0_op = 3'b000;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL opchg_accept got %b exp 1", req0_ready); end
    step(); req0_valid = 0; req0_a = 32'd1;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL opchg_rsp got v%b res %0d z%b exp v1 res 0 z1", rsp0_valid, rsp_result, rsp_zero); end
    checks++; if (alu_a !== 32'd25) begin errors++; $display("FAIL opchg_alu_a_hold got %0d exp 25", alu_a); end
    step();
  endtask

  task automatic test_reset_mid();
    step();
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd8; req1_op = 3'b000; rsp1_ready = 0;
    @(negedge clk);
    step(); req1_valid = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_resp got %b exp 1", rsp1_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b%b exp 00", rsp0_valid, rsp1_valid); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'b000) begin errors++; $display("FAIL rstmid_alu got %0d/%0d/%b exp 0/0/000", alu_a, alu_b, alu_control); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_data got %0d/%b exp 0/0", rsp_result, rsp_zero); end
    @(negedge clk);
    rst_n = 1'b1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost cycle %0d got %b%b exp 00", i, rsp0_valid, rsp1_valid); end
    end
    // Request already waiting at reset release is taken on the first edge
    rst_n = 1'b0;
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 3'b001;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_reset got %b exp 0", req0_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL first_grant_ready got %b exp 1", req0_ready); end
    step(); req0_valid = 0;
    checks++; if (alu_a !== 32'd9 || alu_control !== 3'b001) begin errors++; $display("FAIL first_grant_latch got %0d/%b exp 9/001", alu_a, alu_control); end
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd13) begin errors++; $display("FAIL first_grant_rsp got v%b res %0d exp v1 res 13", rsp0_valid, rsp_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
